// File: rtl/mem_port_arbiter.sv
// Shares the unified instruction/data memory port between the CPU and the
// debug/loader port, with fixed wait states and a one-cycle ack per access.
module mem_port_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic CPU = 1'b0;
  localparam logic DBG = 1'b1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          pick_dbg;

  // On a tie the requester that did not win last time gets the port.
  assign pick_dbg = dbg_req & (~cpu_req | (last_grant == CPU));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= DBG;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req | dbg_req) begin
            state      <= ACCESS;
            cnt        <= CW'(WAIT - 1);
            last_grant <= pick_dbg;
            lat_we     <= pick_dbg ? dbg_we    : cpu_we;
            lat_addr   <= pick_dbg ? dbg_addr  : cpu_addr;
            lat_wdata  <= pick_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!lat_we) rdata <= mem_rdata;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_ack   = (state == RESP) & (last_grant == CPU);
  assign dbg_ack   = (state == RESP) & (last_grant == DBG);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: WAIT=2 main instance plus a
// WAIT=1 instance for the short-access and mid-access reset cases.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic        cpu_ack, dbg_ack, mem_en, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;

  logic        rst1, c1_req, c1_we, d1_req, d1_we;
  logic [31:0] c1_addr, c1_wdata, d1_addr, d1_wdata, m1_rdata;
  logic        c1_ack, d1_ack, m1_en, m1_we, busy1;
  logic [31:0] rdata1, m1_addr, m1_wdata;

  int tests = 0;
  int fails = 0;
  time t_ack, t_prev;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT(2)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT(1)) u_dut1 (
    .clk(clk), .reset(rst1),
    .cpu_req(c1_req), .cpu_we(c1_we),
    .cpu_addr(c1_addr), .cpu_wdata(c1_wdata), .cpu_ack(c1_ack),
    .dbg_req(d1_req), .dbg_we(d1_we),
    .dbg_addr(d1_addr), .dbg_wdata(d1_wdata), .dbg_ack(d1_ack),
    .rdata(rdata1), .mem_en(m1_en), .mem_we(m1_we),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;
    rst1 = 1'b1; c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0;
    c1_wdata = '0; d1_req = 1'b0; d1_we = 1'b0; d1_addr = '0;
    d1_wdata = '0; m1_rdata = '0;

    // reset held 2 cycles with cpu_req high
    tick();
    tick();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", {cpu_ack, dbg_ack}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0; rst1 = 1'b0;
    tick();
    chk("post_rst_grant", {busy, mem_en}, 2'b11);
    tick();
    tick();
    chk("post_rst_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    tick();
    chk("post_rst_idle", busy, 0);

    // CPU read with address change during ACCESS
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    mem_rdata = 32'hDEADBEEF;
    tick();
    chk("rd_acc1", {mem_en, mem_we, cpu_ack}, 3'b100);
    chk("rd_addr1", mem_addr, 32'h10);
    cpu_addr = 32'h20;
    tick();
    chk("rd_acc2", mem_en, 1);
    chk("rd_addr_latched", mem_addr, 32'h10);
    tick();
    chk("rd_ack", {cpu_ack, dbg_ack, mem_en}, 3'b100);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    tick();
    chk("rd_ack_pulse", {cpu_ack, busy}, 0);

    // Debug write, rdata must keep prior read value
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40;
    dbg_wdata = 32'h12345678; mem_rdata = 32'hBAD0BAD0;
    tick();
    chk("wr_acc1", {mem_en, mem_we}, 2'b11);
    chk("wr_addr", mem_addr, 32'h40);
    chk("wr_wdata", mem_wdata, 32'h12345678);
    tick();
    chk("wr_acc2", {mem_en, mem_we}, 2'b11);
    tick();
    chk("wr_ack", {cpu_ack, dbg_ack, mem_we}, 3'b010);
    chk("wr_rdata_hold", rdata, 32'hDEADBEEF);
    dbg_req = 1'b0; dbg_we = 1'b0;
    tick();
    chk("wr_idle", busy, 0);

    // Contention: last grant was DBG, so CPU first, then alternate
    cpu_req = 1'b1; cpu_addr = 32'h100;
    dbg_req = 1'b1; dbg_addr = 32'h200;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ct_addr", mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      tick();
      tick();
      chk("ct_acks", {cpu_ack, dbg_ack},
          (i % 2 == 0) ? 2'b10 : 2'b01);
      t_ack = $time;
      if (i > 0) chk("ct_spacing", t_ack - t_prev, 40);
      t_prev = t_ack;
      if (i == 3) begin
        cpu_req = 1'b0; dbg_req = 1'b0;
      end
      tick();
      chk("ct_idle", {busy, cpu_ack, dbg_ack}, 0);
    end
    tick();
    chk("ct_done", busy, 0);

    // WAIT=1 single read: ack at t+2
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h80;
    m1_rdata = 32'hCAFEF00D;
    tick();
    chk("w1_acc", {m1_en, c1_ack}, 2'b10);
    chk("w1_addr", m1_addr, 32'h80);
    tick();
    chk("w1_ack", {c1_ack, d1_ack, m1_en}, 3'b100);
    chk("w1_rdata", rdata1, 32'hCAFEF00D);
    c1_req = 1'b0;
    tick();
    chk("w1_idle", {busy1, c1_ack}, 0);

    // WAIT=1 reset during ACCESS: abort, no ack
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 32'h90;
    tick();
    chk("w1r_acc", {m1_en, m1_we}, 2'b11);
    rst1 = 1'b1;
    tick();
    chk("w1r_abort", {m1_en, m1_we, c1_ack, busy1}, 0);
    rst1 = 1'b0; c1_req = 1'b0;
    tick();
    chk("w1r_no_ack", {c1_ack, d1_ack, busy1}, 0);
    chk("w1r_rdata", rdata1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single unified instruction/data memory port between two requesters: the multicycle CPU and a debug/loader port.
- Each requester uses a req/ack handshake. The arbiter grants one requester at a time and latches its command.
- It drives the memory for a fixed number of wait-state cycles, then returns read data with a one-cycle ack pulse.
- It sits between the CPU's memory-address mux and the memory array.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT, 2, memory access cycles per transaction. Legal range is WAIT ≥ 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU requests an access; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- dbg_req  in  1  debug/loader request; same protocol as cpu_req.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  AW  debug address.
- dbg_wdata  in  DW  debug write data.
- dbg_ack  out  1  one-cycle completion pulse to the debug port.
- rdata  out  DW  read data for the transaction being acked; shared by both requesters.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid during the final access cycle.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state = IDLE; cnt = 0; last_grant = DBG; rdata = 0.
  - All ack, mem_en, mem_we and busy outputs = 0.
  - mem_addr and mem_wdata = 0.
- Reset mid-transaction:
  - The transaction is aborted and no ack is issued.
  - mem_en and mem_we are low in the cycle after reset is sampled.
- State machine with three states: IDLE, ACCESS, RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_grant. After reset, this means the CPU wins the first tie.
  - On grant: latch we/addr/wdata from the granted requester, set last_grant, set cnt = WAIT-1, go to ACCESS.
- ACCESS:
  - mem_en = 1 and mem_we = latched we.
  - mem_addr and mem_wdata come from the latch; requester inputs are ignored.
  - If cnt ≠ 0: decrement cnt and stay in ACCESS.
  - If cnt == 0:
    - On a read, capture mem_rdata into rdata.
    - On a write, rdata holds its previous value.
    - Go to RESP.
  - ACCESS therefore lasts exactly WAIT cycles.
- RESP:
  - The granted requester's ack = 1 for exactly one cycle; the other ack stays 0.
  - mem_en = 0 and mem_we = 0.
  - Next state is IDLE, unconditionally.
- Latency: if req is first sampled in IDLE at edge t, then:
  - ACCESS occupies cycles t+1 .. t+WAIT;
  - ack is high in cycle t+WAIT+1;
  - the arbiter is back in IDLE at t+WAIT+2.
- Throughput: at most one transaction per WAIT+2 cycles.
- Requester protocol:
  - The requester drops req in the cycle after it sees ack. If req stays high, it is treated as a new request.
  - If req drops mid-transaction (protocol violation), the access still completes and ack still pulses.
- Fairness: with both reqs held continuously, grants strictly alternate.
- busy = 1 in ACCESS and RESP.
- Widths: addresses and data pass through unmodified, with no alignment check or arithmetic. cnt is clog2(WAIT) bits wide, minimum 1 bit.

Test Plan:
- Reset: assert reset 2 cycles with cpu_req=1 → no ack; mem_en=0, busy=0, rdata=0. After release, CPU is granted next cycle.
- CPU read, WAIT=2: cpu_req=1, cpu_addr=0x10, mem_rdata=0xDEADBEEF → mem_en high 2 cycles with mem_addr=0x10; cpu_ack high in 3rd cycle after sample; rdata=0xDEADBEEF; dbg_ack=0.
- Debug write: dbg_we=1, dbg_addr=0x40, dbg_wdata=0x12345678 → mem_we=1 for WAIT cycles with those values; dbg_ack pulse; rdata unchanged from prior read.
- Contention: both reqs held for 4 transactions → grants go CPU, DBG, CPU, DBG; acks one-hot; each ack WAIT+2 cycles apart.
- Latch stability: change cpu_addr from 0x10 to 0x20 during ACCESS → mem_addr stays 0x10 throughout.
- Boundary, WAIT=1: single read completes with mem_en high 1 cycle and ack at t+2. Separately, reset asserted during ACCESS → mem_en drops next cycle, no ack, state returns to IDLE.
